// File: rtl/mac_pe_os_if.sv
// Result/operand bundle for the output-stationary MAC processing element.
// The controller holds the master end; the PE holds the slave end.
interface mac_pe_os_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 32,
    parameter int K_W   = 16
);
    logic                    start;
    logic [K_W-1:0]          cfg_k;
    logic                    process;
    logic signed [IN_W-1:0]  in_a;
    logic signed [IN_W-1:0]  in_b;
    logic signed [IN_W-1:0]  out_a;
    logic signed [IN_W-1:0]  out_b;
    logic signed [ACC_W-1:0] acc_out;
    logic                    busy;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [ACC_W-1:0] res_data;
    logic                    ovf;

    modport master (
        output start, cfg_k, process, in_a, in_b, res_ready,
        input  out_a, out_b, acc_out, busy, res_valid, res_data, ovf
    );

    modport slave (
        input  start, cfg_k, process, in_a, in_b, res_ready,
        output out_a, out_b, acc_out, busy, res_valid, res_data, ovf
    );
endinterface

// File: rtl/mac_pe_os.sv
// Output-stationary signed MAC PE with start/done FSM and valid/ready result.
// Define PE_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mac_pe_os #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 32,
    parameter int K_W   = 16
) (
    input logic         clk,
    input logic         rst,
    mac_pe_os_if.slave  pe
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state;
    logic [K_W-1:0]          k_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [2*IN_W-1:0] p2;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] nxt;
    logic                    ov;
    logic                    go;

    assign p2   = (2*IN_W)'(pe.in_a) * (2*IN_W)'(pe.in_b);
    assign prod = ACC_W'(p2);
    assign sum  = acc + prod;
    assign ov   = (acc[ACC_W-1] == prod[ACC_W-1]) &&
                  (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef PE_SAT_EN
    assign nxt = ov ? (prod[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    assign nxt = sum;
`endif

    // A tile may launch from IDLE, or straight out of DONE once the result is taken.
    assign go = pe.start &&
                ((state == IDLE) || ((state == DONE) && pe.res_ready));

    assign pe.acc_out = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            k_cnt        <= '0;
            acc          <= '0;
            pe.out_a     <= '0;
            pe.out_b     <= '0;
            pe.res_data  <= '0;
            pe.busy      <= 1'b0;
            pe.res_valid <= 1'b0;
            pe.ovf       <= 1'b0;
        end else begin
            if (pe.process) begin
                pe.out_a <= pe.in_a;
                pe.out_b <= pe.in_b;
            end
            if (go) begin
                acc    <= '0;
                pe.ovf <= 1'b0;
                if (pe.cfg_k == '0) begin
                    state        <= DONE;
                    pe.busy      <= 1'b0;
                    pe.res_valid <= 1'b1;
                    pe.res_data  <= '0;
                end else begin
                    state        <= ACCUM;
                    k_cnt        <= pe.cfg_k;
                    pe.busy      <= 1'b1;
                    pe.res_valid <= 1'b0;
                end
            end else begin
                unique case (state)
                    ACCUM: begin
                        if (pe.process) begin
                            acc   <= nxt;
                            k_cnt <= k_cnt - 1'b1;
                            if (ov)
                                pe.ovf <= 1'b1;
                            if (k_cnt == K_W'(1)) begin
                                state        <= DONE;
                                pe.busy      <= 1'b0;
                                pe.res_valid <= 1'b1;
                                pe.res_data  <= nxt;
                            end
                        end
                    end
                    DONE: begin
                        if (pe.res_ready) begin
                            state        <= IDLE;
                            pe.res_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
